// File: rtl/imul_seq_pkg.sv
// ============================================================================
// imul_seq_pkg : shared definitions for the iterative shift-add multiplier
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package imul_seq_pkg;

  // Default operand width; the product is twice this wide.
  localparam int IMUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IMUL_ST_IDLE = 2'd0,
    IMUL_ST_RUN  = 2'd1,
    IMUL_ST_DONE = 2'd2
  } imul_state_t;

endpackage

`default_nettype wire

// File: rtl/imul_shift_add_dp.sv
// ============================================================================
// imul_shift_add_dp : radix-2 shift-add datapath (multiplicand, acc/multiplier
//                     shift register, WIDTH+1-bit adder, iteration counter)
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module imul_shift_add_dp
  import imul_seq_pkg::*;
#(
  parameter int WIDTH = IMUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product_next
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;

  // The extra sum bit keeps the carry so the right shift loses nothing.
  always_comb begin
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
  end

  // Value {acc, mplier} takes after this step; on the last step it is the product.
  assign product_next = {sum, mplier[WIDTH-1:1]};
  assign last         = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/imul_seq.sv
// ============================================================================
// imul_seq : iterative multiplier, WIDTH cycles per 2*WIDTH-bit product.
//            Define IMUL_SIGNED_EN for two's-complement operands and result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imul_seq
  import imul_seq_pkg::*;
#(
  parameter int WIDTH = IMUL_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult
);

  imul_state_t        state;
  logic               accept;
  logic               running;
  logic               last;
  logic               sign;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result_next;

  assign accept  = iStart && ((state == IMUL_ST_IDLE) || (state == IMUL_ST_DONE));
  assign running = (state == IMUL_ST_RUN);

`ifdef IMUL_SIGNED_EN
  // Magnitudes are WIDTH bits, so the most negative operand still fits.
  assign a_mag = iA[WIDTH-1] ? (~iA + 1'b1) : iA;
  assign b_mag = iB[WIDTH-1] ? (~iB + 1'b1) : iB;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sign <= 1'b0;
    end else if (accept) begin
      sign <= iA[WIDTH-1] ^ iB[WIDTH-1];
    end
  end
`else
  assign a_mag = iA;
  assign b_mag = iB;
  assign sign  = 1'b0;
`endif

  assign result_next = sign ? (~product + 1'b1) : product;

  imul_shift_add_dp #(
    .WIDTH        (WIDTH)
  ) u_dp (
    .clk          (Clock),
    .rst_n        (Reset),
    .load         (accept),
    .step         (running),
    .mcand_in     (a_mag),
    .mplier_in    (b_mag),
    .last         (last),
    .product_next (product)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IMUL_ST_IDLE;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
    end else begin
      case (state)
        IMUL_ST_IDLE: begin
          if (iStart) begin
            state <= IMUL_ST_RUN;
            oBusy <= 1'b1;
          end
        end
        IMUL_ST_RUN: begin
          if (last) begin
            state   <= IMUL_ST_DONE;
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oResult <= result_next;
          end
        end
        IMUL_ST_DONE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state <= IMUL_ST_RUN;
            oBusy <= 1'b1;
          end else begin
            state <= IMUL_ST_IDLE;
          end
        end
        default: begin
          state <= IMUL_ST_IDLE;
          oBusy <= 1'b0;
          oDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imul_seq.sv
// ============================================================================
// tb_imul_seq : directed self-checking bench for imul_seq (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imul_seq;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int n_checks = 0;
  int n_errors = 0;

  imul_seq #(.WIDTH(16)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
`ifdef IMUL_SIGNED_EN
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {16'd0, a} * {16'd0, b};
`endif
  endfunction

  // Start one product, follow it for the fixed 16-cycle latency and check the hold cycle.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
    logic busy_ok;
    @(negedge Clock);
    iStart = 1'b1;
    iA     = a;
    iB     = b;
    @(posedge Clock); #1;
    check({tag, " busy@E0"}, oBusy, 1);
    iStart = 1'b0;
    iA     = 16'hDEAD;
    iB     = 16'hBEEF;
    busy_ok = 1'b1;
    repeat (15) begin
      @(posedge Clock); #1;
      if (!oBusy || oDone) busy_ok = 1'b0;
    end
    check({tag, " busy E1..E15"}, busy_ok, 1);
    @(posedge Clock); #1;
    check({tag, " done@E16"}, oDone, 1);
    check({tag, " busy@E16"}, oBusy, 0);
    check({tag, " result"}, oResult, exp);
    @(posedge Clock); #1;
    check({tag, " done drop"}, oDone, 0);
    check({tag, " result hold"}, oResult, exp);
  endtask

  logic        b2b_ok;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    Reset  = 1'b0;
    iStart = 1'b0;
    iA     = '0;
    iB     = '0;
    #12;
    check("reset busy", oBusy, 0);
    check("reset done", oDone, 0);
    check("reset result", oResult, 0);
    @(negedge Clock);
    Reset = 1'b1;

    run_mul("3x5", 16'd3, 16'd5, 32'h0000_000F);
    run_mul("0x1234", 16'h0000, 16'h1234, 32'h0000_0000);
    run_mul("1234x5678", 16'h1234, 16'h5678, 32'h0626_0060);
`ifdef IMUL_SIGNED_EN
    run_mul("FFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    run_mul("FFFEx3", 16'hFFFE, 16'h0003, 32'hFFFF_FFFA);
    run_mul("8000x8000", 16'h8000, 16'h8000, 32'h4000_0000);
    run_mul("7FFFx8000", 16'h7FFF, 16'h8000, 32'hC000_8000);
`else
    run_mul("FFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_mul("FFFEx3", 16'hFFFE, 16'h0003, 32'h0002_FFFA);
    run_mul("8000x8000", 16'h8000, 16'h8000, 32'h4000_0000);
    run_mul("7FFFx8000", 16'h7FFF, 16'h8000, 32'h3FFF_8000);
`endif

    // Back-to-back: start held high; new operands must wait for DONE.
    @(negedge Clock);
    iStart = 1'b1;
    iA     = 16'd7;
    iB     = 16'd9;
    @(posedge Clock); #1;
    check("b2b busy@E0", oBusy, 1);
    iA = 16'h0100;
    iB = 16'h0100;
    repeat (15) @(posedge Clock);
    #1;
    check("b2b busy@E15", oBusy, 1);
    @(posedge Clock); #1;
    check("b2b first done", oDone, 1);
    check("b2b first result", oResult, 32'h0000_003F);
    @(posedge Clock); #1;
    check("b2b no gap busy", oBusy, 1);
    check("b2b done drop", oDone, 0);
    iStart = 1'b0;
    b2b_ok = 1'b1;
    repeat (15) begin
      @(posedge Clock); #1;
      if (!oBusy || oDone || oResult !== 32'h0000_003F) b2b_ok = 1'b0;
    end
    check("b2b second run busy/hold", b2b_ok, 1);
    @(posedge Clock); #1;
    check("b2b second done", oDone, 1);
    check("b2b second result", oResult, 32'h0001_0000);
    @(posedge Clock); #1;

    // Asynchronous reset in the middle of a run.
    @(negedge Clock);
    iStart = 1'b1;
    iA     = 16'h00FF;
    iB     = 16'h0101;
    @(posedge Clock); #1;
    iStart = 1'b0;
    repeat (8) @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    check("midreset busy", oBusy, 0);
    check("midreset done", oDone, 0);
    check("midreset result", oResult, 0);
    @(negedge Clock);
    Reset = 1'b1;
    run_mul("after reset", 16'h00FF, 16'h0101, 32'h0000_FFFF);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_mul($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
